// File: rtl/tlb_pkg.sv
// ============================================================================
// tlb_pkg: shared op codes, CP0 select codes, field positions and FSM states
//          for the TLB maintenance sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

package tlb_pkg;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  localparam logic [1:0] SEL_INDEX    = 2'b00;
  localparam logic [1:0] SEL_ENTRYHI  = 2'b01;
  localparam logic [1:0] SEL_ENTRYLO0 = 2'b10;
  localparam logic [1:0] SEL_ENTRYLO1 = 2'b11;

  localparam int INDEX_P_BIT = 31;

  localparam int EHI_VPN2_HI = 31;
  localparam int EHI_VPN2_LO = 13;
  localparam int EHI_ASID_HI = 7;
  localparam int EHI_ASID_LO = 0;

  localparam int ELO_PFN_HI = 25;
  localparam int ELO_PFN_LO = 6;
  localparam int ELO_C_HI   = 5;
  localparam int ELO_C_LO   = 3;
  localparam int ELO_D_BIT  = 2;
  localparam int ELO_V_BIT  = 1;
  localparam int ELO_G_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    logic        g;
  } entrylo_t;

  function automatic logic is_write_op(input logic [1:0] op);
    return (op == OP_TLBWI) || (op == OP_TLBWR);
  endfunction

  function automatic entrylo_t elo_unpack(input logic [ELO_PFN_HI:0] w);
    entrylo_t e;
    e.pfn = w[ELO_PFN_HI:ELO_PFN_LO];
    e.c   = w[ELO_C_HI:ELO_C_LO];
    e.d   = w[ELO_D_BIT];
    e.v   = w[ELO_V_BIT];
    e.g   = w[ELO_G_BIT];
    return e;
  endfunction

  function automatic logic [31:0] elo_pack(input entrylo_t e);
    logic [31:0] w;
    w = '0;
    w[ELO_PFN_HI:ELO_PFN_LO] = e.pfn;
    w[ELO_C_HI:ELO_C_LO]     = e.c;
    w[ELO_D_BIT]             = e.d;
    w[ELO_V_BIT]             = e.v;
    w[ELO_G_BIT]             = e.g;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlb_random_ctr.sv
// ============================================================================
// tlb_random_ctr: CP0 Random down-counter, wraps from 0 to TLBNUM-1.
// Built only when TLB_RANDOM_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

`ifdef TLB_RANDOM_EN
module tlb_random_ctr #(
  parameter int  TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [IW-1:0] random_idx
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      random_idx <= IW'(TLBNUM - 1);
    end else if (random_idx == '0) begin
      random_idx <= IW'(TLBNUM - 1);
    end else begin
      random_idx <= random_idx - 1'b1;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/tlb_op_ctrl.sv
// ============================================================================
// tlb_op_ctrl: TLBP/TLBR/TLBWI/TLBWR sequencer owning CP0 Index/EntryHi/EntryLo.
// Optional macro TLB_RANDOM_EN: hardware Random counter drives TLBWR's index.
// Rev 1.0
// ============================================================================
`default_nettype none

module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int  TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  output logic          op_ready,
  output logic          op_done,
  output logic          refetch,
  input  logic          mtc0_we,
  input  logic [1:0]    mtc0_sel,
  input  logic [31:0]   mtc0_wdata,
  output logic [31:0]   cp0_index,
  output logic [31:0]   cp0_entryhi,
  output logic [31:0]   cp0_entrylo0,
  output logic [31:0]   cp0_entrylo1,
  output logic [18:0]   s1_vpn2,
  output logic [7:0]    s1_asid,
  output logic          s1_odd_page,
  input  logic          s1_found,
  input  logic [IW-1:0] s1_index,
  output logic          we,
  output logic [IW-1:0] w_index,
  output logic [18:0]   w_vpn2,
  output logic [7:0]    w_asid,
  output logic          w_g,
  output logic [19:0]   w_pfn0,
  output logic [2:0]    w_c0,
  output logic          w_d0,
  output logic          w_v0,
  output logic [19:0]   w_pfn1,
  output logic [2:0]    w_c1,
  output logic          w_d1,
  output logic          w_v1,
  output logic [IW-1:0] r_index,
  input  logic [18:0]   r_vpn2,
  input  logic [7:0]    r_asid,
  input  logic          r_g,
  input  logic [19:0]   r_pfn0,
  input  logic [2:0]    r_c0,
  input  logic          r_d0,
  input  logic          r_v0,
  input  logic [19:0]   r_pfn1,
  input  logic [2:0]    r_c1,
  input  logic          r_d1,
  input  logic          r_v1
);

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    op_q;
  logic          accept;

  logic          index_p;
  logic [IW-1:0] index_val;
  logic [18:0]   ehi_vpn2;
  logic [7:0]    ehi_asid;
  entrylo_t      lo0;
  entrylo_t      lo1;

  assign accept = op_valid && op_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q  <= OP_TLBP;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= op_code;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    op_done   = 1'b0;
    refetch   = 1'b0;
    we        = 1'b0;
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        we        = is_write_op(op_q);
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        op_done   = 1'b1;
        refetch   = is_write_op(op_q);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // MTC0 lands only in IDLE, so it can never collide with an EXEC update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_p   <= 1'b0;
      index_val <= '0;
      ehi_vpn2  <= '0;
      ehi_asid  <= '0;
      lo0       <= '0;
      lo1       <= '0;
    end else if (state == ST_IDLE) begin
      if (mtc0_we) begin
        case (mtc0_sel)
          SEL_INDEX: index_val <= mtc0_wdata[IW-1:0];
          SEL_ENTRYHI: begin
            ehi_vpn2 <= mtc0_wdata[EHI_VPN2_HI:EHI_VPN2_LO];
            ehi_asid <= mtc0_wdata[EHI_ASID_HI:EHI_ASID_LO];
          end
          SEL_ENTRYLO0: lo0 <= elo_unpack(mtc0_wdata[ELO_PFN_HI:0]);
          default:      lo1 <= elo_unpack(mtc0_wdata[ELO_PFN_HI:0]);
        endcase
      end
    end else if (state == ST_EXEC) begin
      case (op_q)
        OP_TLBP: begin
          index_p   <= ~s1_found;
          index_val <= s1_found ? s1_index : '0;
        end
        OP_TLBR: begin
          ehi_vpn2 <= r_vpn2;
          ehi_asid <= r_asid;
          lo0      <= '{pfn: r_pfn0, c: r_c0, d: r_d0, v: r_v0, g: r_g};
          lo1      <= '{pfn: r_pfn1, c: r_c1, d: r_d1, v: r_v1, g: r_g};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cp0_index                              = '0;
    cp0_index[INDEX_P_BIT]                 = index_p;
    cp0_index[IW-1:0]                      = index_val;
    cp0_entryhi                            = '0;
    cp0_entryhi[EHI_VPN2_HI:EHI_VPN2_LO]   = ehi_vpn2;
    cp0_entryhi[EHI_ASID_HI:EHI_ASID_LO]   = ehi_asid;
  end

  assign cp0_entrylo0 = elo_pack(lo0);
  assign cp0_entrylo1 = elo_pack(lo1);

  assign s1_vpn2     = ehi_vpn2;
  assign s1_asid     = ehi_asid;
  assign s1_odd_page = 1'b0;
  assign r_index     = index_val;

  assign w_vpn2 = ehi_vpn2;
  assign w_asid = ehi_asid;
  assign w_g    = lo0.g & lo1.g;
  assign w_pfn0 = lo0.pfn;
  assign w_c0   = lo0.c;
  assign w_d0   = lo0.d;
  assign w_v0   = lo0.v;
  assign w_pfn1 = lo1.pfn;
  assign w_c1   = lo1.c;
  assign w_d1   = lo1.d;
  assign w_v1   = lo1.v;

`ifdef TLB_RANDOM_EN
  logic [IW-1:0] random_idx;

  tlb_random_ctr #(
    .TLBNUM (TLBNUM)
  ) u_random_ctr (
    .clk        (clk),
    .reset      (reset),
    .random_idx (random_idx)
  );

  assign w_index = (op_q == OP_TLBWR) ? random_idx : index_val;
`else
  // Without a Random register TLBWR degenerates to TLBWI.
  assign w_index = index_val;
`endif

endmodule

`default_nettype wire
